// File: rtl/id_stage_if.sv
// id_stage_if: fetch-side and execute-side handshake bundle of the decode stage.
// Both sides use valid/ready: a beat transfers on a rising edge where valid and
// ready are both high; the producer holds valid and payload stable until then.
interface id_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 6,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_inst;
    logic             in_svpc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_lhs;
    logic [XLEN-1:0]  out_rhs;
    logic [XLEN-1:0]  out_imm;
    logic [OPW-1:0]   out_opcode;
    logic [RADDR-1:0] out_rd;

    // Fetch/execute environment side
    modport master (
        output in_valid, in_pc, in_inst, in_svpc, out_ready,
        input  in_ready, out_valid, out_pc, out_lhs, out_rhs, out_imm,
               out_opcode, out_rd
    );

    // Decode stage side
    modport slave (
        input  in_valid, in_pc, in_inst, in_svpc, out_ready,
        output in_ready, out_valid, out_pc, out_lhs, out_rhs, out_imm,
               out_opcode, out_rd
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction decode stage with register file, load-use interlock,
// flush and saturating stall counter. Optional macro ID_BYPASS_EN makes a
// same-cycle write-back visible to the register reads.
module id_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 6,
    parameter int OPW   = 4,
    parameter int SCW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_stage_if.slave        bus,
    input  logic             ex_load,
    input  logic [RADDR-1:0] ex_rd,
    input  logic             wb_en,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic [SCW-1:0]   stall_cnt
);
    localparam int NREG = 2 ** RADDR;
    localparam int F    = XLEN - OPW;
    localparam int IWL  = F - RADDR;      // long immediate width (inst[0]=1)
    localparam int IWS  = F - 2 * RADDR;  // short immediate width (inst[0]=0)

`ifdef ID_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  regs [NREG];
    logic [OPW-1:0]   opcode;
    logic [RADDR-1:0] rd, rs1, rs2;
    logic [XLEN-1:0]  imm, imm_long, imm_short;
    logic [XLEN-1:0]  rs1_val, rs2_val, lhs;
    logic             hazard, accept;

    assign opcode    = bus.in_inst[XLEN-1 -: OPW];
    assign rd        = bus.in_inst[F-1 -: RADDR];
    assign rs1       = bus.in_inst[F-RADDR-1 -: RADDR];
    assign rs2       = bus.in_inst[F-2*RADDR-1 -: RADDR];
    assign imm_long  = {{(XLEN-IWL){bus.in_inst[IWL-1]}}, bus.in_inst[IWL-1:0]};
    assign imm_short = {{(XLEN-IWS){bus.in_inst[IWS-1]}}, bus.in_inst[IWS-1:0]};
    assign imm       = bus.in_inst[0] ? imm_long : imm_short;

    // Register reads: r0 is hardwired zero; optional write-back forwarding
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (BYPASS && wb_en && (wb_rd != '0) && (wb_rd == rs1)) rs1_val = wb_data;
        if (BYPASS && wb_en && (wb_rd != '0) && (wb_rd == rs2)) rs2_val = wb_data;
        if (rs1 == '0) rs1_val = '0;
        if (rs2 == '0) rs2_val = '0;
    end

    assign lhs = bus.in_svpc ? bus.in_pc : rs1_val;

    // Load-use interlock: rs1 only matters when it actually feeds lhs
    assign hazard = bus.in_valid && ex_load && (ex_rd != '0) &&
                    ((ex_rd == rs2) || ((ex_rd == rs1) && !bus.in_svpc));

    assign bus.in_ready = !flush && !hazard && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Register file write-back; writes to r0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Output pipeline register: flush wins, then accept, then consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_pc     <= '0;
            bus.out_lhs    <= '0;
            bus.out_rhs    <= '0;
            bus.out_imm    <= '0;
            bus.out_opcode <= '0;
            bus.out_rd     <= '0;
        end else if (flush) begin
            bus.out_valid  <= 1'b0;
        end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.out_pc     <= bus.in_pc;
            bus.out_lhs    <= lhs;
            bus.out_rhs    <= rs2_val;
            bus.out_imm    <= imm;
            bus.out_opcode <= opcode;
            bus.out_rd     <= rd;
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end

    // Count interlock cycles, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + SCW'(1);
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized and directed bench for id_stage against a
// transaction-level reference model (register array + expected bundle queue).
module tb_id_stage;
    localparam int BW = 4 * 32 + 4 + 6;

    logic        clk;
    logic        rst;
    logic        ex_load;
    logic [5:0]  ex_rd;
    logic        wb_en;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [15:0] stall_cnt;

    id_stage_if #(.XLEN(32), .RADDR(6), .OPW(4)) bus ();

    id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ex_load   (ex_load),
        .ex_rd     (ex_rd),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    // Reference model state
    logic [31:0]   exp_regs [64];
    logic [BW-1:0] exp_q[$];
    int            exp_cnt;
    int            checks;
    int            errors;

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] make_inst(int opc, int rd, int rs1, int rs2, int low);
        longint v;
        v = longint'(opc) * (64'd1 << 28) + longint'(rd) * (64'd1 << 22) +
            longint'(rs1) * (64'd1 << 16) + longint'(rs2) * (64'd1 << 10) + longint'(low);
        return 32'(v);
    endfunction

    function automatic int fld(logic [31:0] inst, int shift);
        return int'((inst >> shift) & 32'h3F);
    endfunction

    function automatic logic [31:0] m_imm(logic [31:0] inst);
        longint v;
        if (inst % 2 == 1) begin
            v = longint'(inst & 32'h3FFFFF);
            if (v >= 2 ** 21) v = v - 2 ** 22;
        end else begin
            v = longint'(inst & 32'hFFFF);
            if (v >= 2 ** 15) v = v - 2 ** 16;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_read(int idx);
        if (idx == 0) return 32'h0;
`ifdef ID_BYPASS_EN
        if (wb_en && int'(wb_rd) == idx) return wb_data;
`endif
        return exp_regs[idx];
    endfunction

    function automatic bit m_hazard();
        int rs1, rs2;
        rs1 = fld(bus.in_inst, 16);
        rs2 = fld(bus.in_inst, 10);
        return bus.in_valid && ex_load && ex_rd != 6'd0 &&
               (int'(ex_rd) == rs2 || (int'(ex_rd) == rs1 && !bus.in_svpc));
    endfunction

    function automatic bit m_ready();
        return !flush && !m_hazard() && (exp_q.size() == 0 || bus.out_ready);
    endfunction

    function automatic logic [BW-1:0] m_decode();
        logic [31:0] lhs;
        lhs = bus.in_svpc ? bus.in_pc : m_read(fld(bus.in_inst, 16));
        return {bus.in_pc, lhs, m_read(fld(bus.in_inst, 10)), m_imm(bus.in_inst),
                4'(bus.in_inst >> 28), 6'(fld(bus.in_inst, 22))};
    endfunction

    function automatic logic [BW-1:0] m_front();
        return (exp_q.size() != 0) ? exp_q[0] : '0;
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {bus.out_pc, bus.out_lhs, bus.out_rhs, bus.out_imm, bus.out_opcode, bus.out_rd};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) exp_regs[i] = 32'h0;
        exp_q.delete();
        exp_cnt = 0;
    endtask

    // Advance one clock: update model from current inputs, end at edge + 1
    task automatic tick();
        bit            acc;
        logic [BW-1:0] nb;
        acc = bus.in_valid && m_ready();
        nb  = m_decode();
        if (flush) exp_q.delete();
        else if (acc) begin
            exp_q.delete();
            exp_q.push_back(nb);
        end else if (bus.out_ready && exp_q.size() != 0) exp_q.delete(0);
        if (m_hazard() && exp_cnt != 65535) exp_cnt++;
        if (wb_en && wb_rd != 6'd0) exp_regs[wb_rd] = wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'h0;
        bus.in_inst   = 32'h0;
        bus.in_svpc   = 1'b0;
        bus.out_ready = 1'b1;
        ex_load       = 1'b0;
        ex_rd         = 6'd0;
        wb_en         = 1'b0;
        wb_rd         = 6'd0;
        wb_data       = 32'h0;
        flush         = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_valid_cnt got %0b/%0d want 0/0", bus.out_valid, stall_cnt);
        end
        checks++;
        if (dut_bundle() !== '0) begin
            errors++;
            $display("FAIL reset_bundle got %h want 0", dut_bundle());
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
        end
        rst = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic test_basic();
        idle();
        wb_en = 1'b1; wb_rd = 6'd5; wb_data = 32'h1234;
        tick();
        wb_rd = 6'd6; wb_data = 32'hFFFF0000;
        tick();
        wb_en = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h100;
        bus.in_inst  = make_inst(1, 1, 5, 6, 0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready got %0b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_opcode !== 4'd1 || bus.out_rd !== 6'd1) begin
            errors++;
            $display("FAIL basic_ctl got v=%0b op=%0d rd=%0d want 1/1/1",
                     bus.out_valid, bus.out_opcode, bus.out_rd);
        end
        checks++;
        if (bus.out_lhs !== 32'h1234 || bus.out_rhs !== 32'hFFFF0000 ||
            bus.out_imm !== 32'h1800 || bus.out_pc !== 32'h100) begin
            errors++;
            $display("FAIL basic_data got %h %h %h %h want 1234 ffff0000 1800 100",
                     bus.out_lhs, bus.out_rhs, bus.out_imm, bus.out_pc);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_consume got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_imm_svpc();
        idle();
        bus.in_valid = 1'b1;
        bus.in_svpc  = 1'b1;
        bus.in_pc    = 32'h40;
        bus.in_inst  = (32'd2 << 28) | (32'd3 << 22) | 32'h200001;
        tick();
        idle();
        checks++;
        if (bus.out_lhs !== 32'h40 || bus.out_imm !== 32'hFFE00001 || bus.out_rhs !== 32'h0) begin
            errors++;
            $display("FAIL imm_svpc got lhs=%h imm=%h rhs=%h want 40 ffe00001 0",
                     bus.out_lhs, bus.out_imm, bus.out_rhs);
        end
        tick();
    endtask

    task automatic test_hazard();
        int start;
        idle();
        bus.in_valid = 1'b1;
        bus.in_inst  = make_inst(5, 9, 5, 7, 4);
        ex_load      = 1'b1;
        ex_rd        = 6'd5;
        start        = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hazard_block cycle %0d got %0b want 0", i, bus.in_ready);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 16'(start + 3) || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hazard_count got %0d v=%0b want %0d v=0", stall_cnt, bus.out_valid, start + 3);
        end
        bus.in_svpc = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hazard_svpc_exempt got %0b want 1", bus.in_ready);
        end
        bus.in_svpc = 1'b0;
        ex_load     = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hazard_release got %0b want 1", bus.in_ready);
        end
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_lhs !== 32'h1234) begin
            errors++;
            $display("FAIL hazard_accept got v=%0b lhs=%h want 1 1234", bus.out_valid, bus.out_lhs);
        end
        tick();
    endtask

    task automatic test_backpressure_flush();
        idle();
        bus.in_valid = 1'b1;
        bus.in_inst  = make_inst(3, 2, 5, 6, 10);
        tick();
        bus.out_ready = 1'b0;
        bus.in_inst   = make_inst(4, 3, 6, 5, 20);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || dut_bundle() !== m_front()) begin
                errors++;
                $display("FAIL hold cycle %0d got rdy=%0b v=%0b b=%h want 0/1/%h",
                         i, bus.in_ready, bus.out_valid, dut_bundle(), m_front());
            end
            tick();
        end
        flush = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %0b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill got %0b want 0", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty_ready got %0b want 0", bus.in_ready);
        end
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_accept got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        idle();
        bus.in_valid = 1'b1;
        bus.in_inst  = make_inst(6, 4, 5, 0, 0);
        wb_en = 1'b1; wb_rd = 6'd5; wb_data = 32'hABCD;
`ifdef ID_BYPASS_EN
        want = 32'hABCD;
`else
        want = 32'h1234;
`endif
        tick();
        wb_en = 1'b0;
        checks++;
        if (bus.out_lhs !== want) begin
            errors++;
            $display("FAIL bypass_same_cycle got %h want %h", bus.out_lhs, want);
        end
        tick();
        idle();
        checks++;
        if (bus.out_lhs !== 32'hABCD) begin
            errors++;
            $display("FAIL bypass_after_write got %h want abcd", bus.out_lhs);
        end
        tick();
    endtask

    task automatic test_r0();
        idle();
        wb_en = 1'b1; wb_rd = 6'd0; wb_data = 32'h55;
        tick();
        wb_en = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst  = make_inst(7, 8, 0, 0, 1);
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_lhs !== 32'h0 || bus.out_rhs !== 32'h0) begin
            errors++;
            $display("FAIL r0_read got v=%0b lhs=%h rhs=%h want 1 0 0", bus.out_valid, bus.out_lhs, bus.out_rhs);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = $urandom;
            bus.in_pc    = $urandom;
            bus.in_svpc  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d got %0b want 1", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || dut_bundle() !== m_front()) begin
                errors++;
                $display("FAIL b2b_bundle cycle %0d got v=%0b %h want 1 %h", i, bus.out_valid, dut_bundle(), m_front());
            end
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_svpc   = ($urandom_range(0, 3) == 0);
            bus.in_pc     = $urandom;
            bus.in_inst   = make_inst($urandom_range(0, 15), $urandom_range(0, 63),
                                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1023));
            ex_load       = ($urandom_range(0, 3) == 0);
            ex_rd         = 6'($urandom_range(0, 7));
            wb_en         = ($urandom_range(0, 1) == 0);
            wb_rd         = 6'($urandom_range(0, 7));
            wb_data       = $urandom;
            flush         = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (bus.in_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready cycle %0d got %0b want %0b", i, bus.in_ready, m_ready());
            end
            checks++;
            if (bus.out_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid cycle %0d got %0b want %0b", i, bus.out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (dut_bundle() !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_bundle cycle %0d got %h want %h", i, dut_bundle(), exp_q[0]);
                end
            end
            checks++;
            if (stall_cnt !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL rand_stall cycle %0d got %0d want %0d", i, stall_cnt, exp_cnt);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'hDEAD0;
        bus.in_inst  = make_inst(9, 9, 5, 6, 3);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || dut_bundle() !== '0 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid got v=%0b b=%h cnt=%0d want all 0", bus.out_valid, dut_bundle(), stall_cnt);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        bus.in_valid = 1'b1;
        bus.in_inst  = make_inst(1, 2, 5, 6, 0);
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_lhs !== 32'h0 || bus.out_rhs !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs_clear got v=%0b lhs=%h rhs=%h want 1 0 0", bus.out_valid, bus.out_lhs, bus.out_rhs);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        model_clear();
        test_reset();
        test_basic();
        test_imm_svpc();
        test_hazard();
        test_backpressure_flush();
        test_bypass();
        test_r0();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
